// File: rtl/axis_reg_cmd_tx.sv
// Register-bus command transmitter: buffers write requests and emits
// each as an address word followed immediately by its data word.
module axis_reg_cmd_tx #(
    parameter int REG_ADDR_WIDTH = 4,
    parameter int ADDR_WIDTH     = 12,
    parameter int FIFO_DEPTH     = 4,
    parameter int GAP_CYCLES     = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_WIDTH-1:0]         req_core_addr,
    input  logic [REG_ADDR_WIDTH-1:0]     req_reg_addr,
    input  logic [31:0]                   req_data,
    input  logic                          req_TVALID,
    output logic                          req_TREADY,
    output logic [31:0]                   cmd_out_TDATA,
    output logic                          cmd_out_TVALID,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = ADDR_WIDTH + REG_ADDR_WIDTH;
    localparam int EW = AW + 32;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, DATA, GAP} state_t;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_nxt;
    logic          push, pop;

    logic [EW-1:0]             head;
    logic [ADDR_WIDTH-1:0]     head_core;
    logic [REG_ADDR_WIDTH-1:0] head_reg;
    logic [31:0]               head_data;
    logic [31:0]               addr_word;
    logic [31:0]               hold_data;

    state_t        state, state_nxt;
    logic [GW-1:0] gap_cnt, gap_nxt;
    logic          tvalid_nxt;
    logic [31:0]   tdata_nxt;

    // Ready comes from the count alone so a full FIFO never pushes,
    // even on a cycle that also pops.
    assign req_TREADY = !rst && (fifo_count != CW'(FIFO_DEPTH));
    assign push       = req_TVALID && req_TREADY;

    assign head      = mem[rd_ptr];
    assign head_core = head[EW-1 -: ADDR_WIDTH];
    assign head_reg  = head[32 +: REG_ADDR_WIDTH];
    assign head_data = head[31:0];

    always_comb begin
        addr_word = '0;
        addr_word[AW-1:0] = {head_core, head_reg};
    end

    always_comb begin
        count_nxt = fifo_count;
        if (push && !pop)
            count_nxt = fifo_count + CW'(1);
        else if (pop && !push)
            count_nxt = fifo_count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {req_core_addr, req_reg_addr, req_data};
    end

    // DATA is the cycle the address word is on the bus; it always
    // schedules the data word next, so a command is never split.
    always_comb begin
        state_nxt  = state;
        gap_nxt    = gap_cnt;
        pop        = 1'b0;
        tvalid_nxt = 1'b0;
        tdata_nxt  = cmd_out_TDATA;
        unique case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop        = 1'b1;
                    tvalid_nxt = 1'b1;
                    tdata_nxt  = addr_word;
                    state_nxt  = DATA;
                end
            end
            DATA: begin
                tvalid_nxt = 1'b1;
                tdata_nxt  = hold_data;
                if (GAP_CYCLES == 0) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = GAP;
                    gap_nxt   = GW'(GAP_CYCLES);
                end
            end
            GAP: begin
                gap_nxt = gap_cnt - GW'(1);
                if (gap_cnt <= GW'(1)) begin
                    state_nxt = IDLE;
                    gap_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            gap_cnt        <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            busy           <= 1'b0;
            hold_data      <= '0;
            cmd_out_TDATA  <= '0;
            cmd_out_TVALID <= 1'b0;
        end else begin
            state          <= state_nxt;
            gap_cnt        <= gap_nxt;
            fifo_count     <= count_nxt;
            busy           <= (count_nxt != '0) || (state_nxt != IDLE);
            cmd_out_TDATA  <= tdata_nxt;
            cmd_out_TVALID <= tvalid_nxt;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + PW'(1);
                hold_data <= head_data;
            end
        end
    end

endmodule

// File: tb/tb_axis_reg_cmd_tx.sv
// Directed bench for axis_reg_cmd_tx: one instance with no gap,
// one with a 2-cycle gap, plus two bench-side register-map decoders.
module tb_axis_reg_cmd_tx;

    logic clk, rst;

    logic [11:0] r0_core, r1_core;
    logic [3:0]  r0_reg, r1_reg;
    logic [31:0] r0_data, r1_data;
    logic        r0_valid, r1_valid, r0_ready, r1_ready;
    logic [31:0] o0_data, o1_data;
    logic        o0_valid, o1_valid;
    logic [2:0]  cnt0, cnt1;
    logic        busy0, busy1;

    int passed = 0;
    int total  = 0;

    axis_reg_cmd_tx #(
        .REG_ADDR_WIDTH(4), .ADDR_WIDTH(12),
        .FIFO_DEPTH(4), .GAP_CYCLES(0)
    ) dut0 (
        .clk(clk), .rst(rst),
        .req_core_addr(r0_core), .req_reg_addr(r0_reg),
        .req_data(r0_data), .req_TVALID(r0_valid),
        .req_TREADY(r0_ready),
        .cmd_out_TDATA(o0_data), .cmd_out_TVALID(o0_valid),
        .fifo_count(cnt0), .busy(busy0)
    );

    axis_reg_cmd_tx #(
        .REG_ADDR_WIDTH(4), .ADDR_WIDTH(12),
        .FIFO_DEPTH(4), .GAP_CYCLES(2)
    ) dut1 (
        .clk(clk), .rst(rst),
        .req_core_addr(r1_core), .req_reg_addr(r1_reg),
        .req_data(r1_data), .req_TVALID(r1_valid),
        .req_TREADY(r1_ready),
        .cmd_out_TDATA(o1_data), .cmd_out_TVALID(o1_valid),
        .fifo_count(cnt1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle log of dut0 output, and two register maps (core 1, 2)
    logic        log0_v[$];
    logic [31:0] log0_d[$];
    logic [35:0] got1[$];
    logic [35:0] got2[$];
    logic        ph0 = 1'b0;
    logic [31:0] hdr0 = '0;

    always @(negedge clk) begin
        log0_v.push_back(o0_valid);
        log0_d.push_back(o0_data);
        if (rst) begin
            ph0 = 1'b0;
        end else if (o0_valid) begin
            if (!ph0) begin
                hdr0 = o0_data;
                ph0  = 1'b1;
            end else begin
                ph0 = 1'b0;
                if (hdr0[31:4] == 28'd1)
                    got1.push_back({hdr0[3:0], o0_data});
                else if (hdr0[31:4] == 28'd2)
                    got2.push_back({hdr0[3:0], o0_data});
            end
        end
    end

    logic        gv[12] = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0};
    logic [31:0] gd[12] = '{0, 32'h31, 32'h1111_1111, 0, 0,
                            32'h42, 32'h2222_2222, 0, 0,
                            32'h53, 32'h3333_3333, 0};

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [11:0] c, input logic [3:0] r,
                         input logic [31:0] d);
        logic acc;
        logic done;
        done     = 1'b0;
        r0_core  = c;
        r0_reg   = r;
        r0_data  = d;
        r0_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            acc = r0_ready;
            step();
            if (acc) begin
                done = 1'b1;
                break;
            end
        end
        r0_valid = 1'b0;
        chk("push_accept", done, 1);
    endtask

    initial begin
        logic [31:0] ew[16];
        logic [35:0] e1[$];
        logic [35:0] e2[$];
        logic [11:0] cl[6];
        logic        acc, rdy, ev;
        int          idx, s, s1, s2, nv;
        logic [3:0]  rr;
        logic [31:0] rd;

        rst = 1'b1;
        r0_core = '0; r0_reg = '0; r0_data = '0; r0_valid = 1'b0;
        r1_core = '0; r1_reg = '0; r1_data = '0; r1_valid = 1'b0;
        step();
        step();
        chk("rst_ready0", r0_ready, 0);
        chk("rst_ready1", r1_ready, 0);
        chk("rst_tvalid", o0_valid, 0);
        chk("rst_tdata", o0_data, 0);
        chk("rst_count", cnt0, 0);
        chk("rst_busy", busy0, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", r0_ready, 1);

        // Single request: core 5, reg 3
        step();
        r0_core = 12'h005; r0_reg = 4'h3;
        r0_data = 32'hDEAD_BEEF; r0_valid = 1'b1;
        step();
        r0_valid = 1'b0;
        chk("t1_count", cnt0, 1);
        chk("t1_idle", o0_valid, 0);
        step();
        chk("t1_a_valid", o0_valid, 1);
        chk("t1_a_word", o0_data, 32'h0000_0053);
        step();
        chk("t1_d_valid", o0_valid, 1);
        chk("t1_d_word", o0_data, 32'hDEAD_BEEF);
        chk("t1_busy", busy0, 0);
        step();
        chk("t1_end_valid", o0_valid, 0);
        chk("t1_hold_data", o0_data, 32'hDEAD_BEEF);

        // Back-to-back 8 requests; FIFO fills, pops while full
        for (int i = 0; i < 8; i++) begin
            ew[2*i]   = {16'h0, 12'(i + 1), 4'(i)};
            ew[2*i+1] = 32'hA000_0000 + 32'(i) * 32'h1111;
        end
        idx = 0;
        s = log0_v.size();
        for (int k = 0; k < 22; k++) begin
            if (idx < 8) begin
                r0_core  = 12'(idx + 1);
                r0_reg   = 4'(idx);
                r0_data  = 32'hA000_0000 + 32'(idx) * 32'h1111;
                r0_valid = 1'b1;
            end else begin
                r0_valid = 1'b0;
            end
            rdy = r0_ready;
            acc = r0_ready && r0_valid;
            if (k == 7) chk("t2_full_ready", rdy, 0);
            if (k == 8) chk("t2_refill_ready", rdy, 1);
            step();
            if (acc) idx++;
            chk("t2_count_le4", cnt0 <= 3'd4, 1);
            if (k == 6) chk("t2_full_count", cnt0, 4);
            if (k == 7) chk("t2_pop_nopush", cnt0, 3);
            if (k == 8) chk("t2_refill_count", cnt0, 4);
        end
        r0_valid = 1'b0;
        for (int j = 0; j <= 18; j++) begin
            ev = (j >= 2) && (j <= 17);
            chk("t2_valid", log0_v[s+j], ev);
            if (ev) chk("t2_word", log0_d[s+j], ew[j-2]);
        end
        chk("t2_busy_end", busy0, 0);

        // GAP_CYCLES=2 instance, 3 requests
        for (int k = 0; k < 12; k++) begin
            if (k < 3) begin
                r1_core  = 12'(k + 3);
                r1_reg   = 4'(k + 1);
                r1_data  = 32'h1111_1111 * 32'(k + 1);
                r1_valid = 1'b1;
                chk("t3_ready", r1_ready, 1);
            end else begin
                r1_valid = 1'b0;
            end
            step();
            chk("t3_valid", o1_valid, gv[k]);
            if (gv[k]) chk("t3_word", o1_data, gd[k]);
        end

        // Reset while the address word is out, two requests queued
        for (int k = 0; k < 4; k++) begin
            r0_core  = 12'h007;
            r0_reg   = 4'(k);
            r0_data  = 32'h5555_0000 + 32'(k);
            r0_valid = 1'b1;
            step();
        end
        r0_valid = 1'b0;
        chk("t4_pre_valid", o0_valid, 1);
        chk("t4_pre_word", o0_data, 32'h0000_0071);
        chk("t4_pre_count", cnt0, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("t4_async_valid", o0_valid, 0);
        chk("t4_async_data", o0_data, 0);
        chk("t4_async_count", cnt0, 0);
        chk("t4_async_ready", r0_ready, 0);
        step();
        rst = 1'b0;
        s = log0_v.size();
        #1;
        chk("t4_rel_ready", r0_ready, 1);
        chk("t4_rel_count", cnt0, 0);
        for (int k = 0; k < 6; k++) step();
        nv = 0;
        for (int j = 0; j < 6; j++) if (log0_v[s+j]) nv++;
        chk("t4_no_words", nv, 0);
        chk("t4_busy", busy0, 0);

        // Loopback through register maps at core 1 and core 2
        cl = '{12'd1, 12'd2, 12'd3, 12'd2, 12'd1, 12'd1};
        s1 = got1.size();
        s2 = got2.size();
        for (int i = 0; i < 6; i++) begin
            rr = 4'($urandom_range(0, 15));
            rd = $urandom;
            if (cl[i] == 12'd1) e1.push_back({rr, rd});
            if (cl[i] == 12'd2) e2.push_back({rr, rd});
            push0(cl[i], rr, rd);
        end
        for (int k = 0; k < 20; k++) step();
        chk("t5_map1_count", got1.size() - s1, e1.size());
        chk("t5_map2_count", got2.size() - s2, e2.size());
        for (int i = 0; i < e1.size(); i++)
            if (s1 + i < got1.size())
                chk("t5_map1_cmd", got1[s1+i], e1[i]);
        for (int i = 0; i < e2.size(); i++)
            if (s2 + i < got2.size())
                chk("t5_map2_cmd", got2[s2+i], e2[i]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
